// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the load/store stage: access-width codes, FSM state
// encoding and small helpers for decoding funct3.
package lsu_stage_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } ls_size_e;

   // Unlisted codes (011/110/111) fall through to a full-word access.
   function automatic ls_size_e ls_size(input logic [2:0] f3);
      ls_size = SZ_W;
      case (f3)
         LS_B, LS_BU: ls_size = SZ_B;
         LS_H, LS_HU: ls_size = SZ_H;
         default:     ls_size = SZ_W;
      endcase
   endfunction

   function automatic logic ls_is_unsigned(input logic [2:0] f3);
      ls_is_unsigned = (f3 == LS_BU) || (f3 == LS_HU);
   endfunction

   function automatic logic ls_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      ls_misaligned = 1'b0;
      case (ls_size(f3))
         SZ_B:    ls_misaligned = 1'b0;
         SZ_H:    ls_misaligned = lo[0];
         default: ls_misaligned = |lo;
      endcase
   endfunction

endpackage

// File: rtl/lsu_stage_align.sv
// Byte-lane steering for the LSU: store mask/data replication and load
// lane selection with sign or zero extension. Purely combinational.
module lsu_align
   import lsu_stage_pkg::*;
(
   input  logic [1:0]      addr_lo_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [3:0]      wmask_o,
   output logic [XLEN-1:0] wdata_o,
   output logic [XLEN-1:0] rdata_o
);

   logic [XLEN-1:0] shifted;
   logic [7:0]      byte_v;
   logic [15:0]     half_v;
   logic            uns;

   always_comb begin
      wmask_o = '0;
      wdata_o = '0;
      rdata_o = '0;
      // Bring the addressed lane down to bit 0 before extending.
      shifted = rdata_i >> {addr_lo_i, 3'b000};
      byte_v  = shifted[7:0];
      half_v  = shifted[15:0];
      uns     = ls_is_unsigned(funct3_i);
      case (ls_size(funct3_i))
         SZ_B: begin
            wmask_o = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = uns ? {{(XLEN-8){1'b0}}, byte_v}
                          : {{(XLEN-8){byte_v[7]}}, byte_v};
         end
         SZ_H: begin
            wmask_o = 4'b0011 << addr_lo_i;
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = uns ? {{(XLEN-16){1'b0}}, half_v}
                          : {{(XLEN-16){half_v[15]}}, half_v};
         end
         default: begin
            wmask_o = 4'b1111;
            wdata_o = wdata_i;
            rdata_o = rdata_i;
         end
      endcase
   end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage: accepts one memory op, issues a single word-aligned
// request, aligns/extends the reply and hands the result to writeback.
module lsu_stage #(
   parameter int          XLEN        = 32,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_addr,
   input  logic [XLEN-1:0] in_wdata,
   input  logic [2:0]      in_funct3,
   input  logic            in_mem_read,
   input  logic            in_mem_write,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_load_data,
   output logic            out_fault,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic            mem_req_wen,
   output logic [XLEN-1:0] mem_req_addr,
   output logic [XLEN-1:0] mem_req_wdata,
   output logic [3:0]      mem_req_wmask,
   input  logic            mem_resp_valid,
   input  logic [XLEN-1:0] mem_resp_rdata
);

   import lsu_stage_pkg::*;

   lsu_state_e      state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [2:0]      funct3_q, funct3_d;
   logic            load_q, load_d;
   logic            store_q, store_d;
   logic [XLEN-1:0] load_data_q, load_data_d;
   logic            fault_q, fault_d;
   logic [31:0]     cnt_q, cnt_d;

   logic [3:0]      al_wmask;
   logic [XLEN-1:0] al_wdata;
   logic [XLEN-1:0] al_rdata;

   lsu_align u_align (
      .addr_lo_i (addr_q[1:0]),
      .funct3_i  (funct3_q),
      .wdata_i   (wdata_q),
      .rdata_i   (mem_resp_rdata),
      .wmask_o   (al_wmask),
      .wdata_o   (al_wdata),
      .rdata_o   (al_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         funct3_q    <= '0;
         load_q      <= 1'b0;
         store_q     <= 1'b0;
         load_data_q <= '0;
         fault_q     <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         funct3_q    <= funct3_d;
         load_q      <= load_d;
         store_q     <= store_d;
         load_data_q <= load_data_d;
         fault_q     <= fault_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      funct3_d    = funct3_q;
      load_d      = load_q;
      store_d     = store_q;
      load_data_d = load_data_q;
      fault_d     = fault_q;
      cnt_d       = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               addr_d      = in_addr;
               wdata_d     = in_wdata;
               funct3_d    = in_funct3;
               load_d      = in_mem_read;
               // A simultaneous read/write request is handled as a load.
               store_d     = in_mem_write & ~in_mem_read;
               load_data_d = '0;
               fault_d     = 1'b0;
               cnt_d       = '0;
               if (!(in_mem_read || in_mem_write)) begin
                  state_d = ST_DONE;
               end else if (ls_misaligned(in_funct3, in_addr[1:0])) begin
                  fault_d = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (mem_req_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 32'd1;
            if (mem_resp_valid) begin
               load_data_d = load_q ? al_rdata : '0;
               state_d     = ST_DONE;
            end else if ((MEM_TIMEOUT != 0) && (cnt_d == MEM_TIMEOUT)) begin
               load_data_d = '0;
               fault_d     = 1'b1;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign in_ready      = (state_q == ST_IDLE);
   assign out_valid     = (state_q == ST_DONE);
   assign out_load_data = load_data_q;
   assign out_fault     = fault_q;

   assign mem_req_valid = (state_q == ST_REQ);
   assign mem_req_wen   = store_q;
   assign mem_req_addr  = {addr_q[XLEN-1:2], 2'b00};
   assign mem_req_wdata = store_q ? al_wdata : '0;
   assign mem_req_wmask = store_q ? al_wmask : 4'b0000;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: loads, stores, misalignment, stalls on both
// handshakes, reset mid-transaction and memory timeout.
module tb_lsu_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic [2:0]  in_funct3;
   logic        in_mem_read;
   logic        in_mem_write;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_load_data;
   logic        out_fault;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_wen;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_rdata;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   lsu_stage #(.XLEN(32), .MEM_TIMEOUT(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_addr        (in_addr),
      .in_wdata       (in_wdata),
      .in_funct3      (in_funct3),
      .in_mem_read    (in_mem_read),
      .in_mem_write   (in_mem_write),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_load_data  (out_load_data),
      .out_fault      (out_fault),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_wen    (mem_req_wen),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wmask  (mem_req_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_rdata (mem_resp_rdata)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  32'(in_ready),      32'd1);
      chk({tag, "_out_valid"}, 32'(out_valid),     32'd0);
      chk({tag, "_load"},      out_load_data,      32'd0);
      chk({tag, "_fault"},     32'(out_fault),     32'd0);
      chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
      chk({tag, "_wen"},       32'(mem_req_wen),   32'd0);
      chk({tag, "_addr"},      mem_req_addr,       32'd0);
      chk({tag, "_wdata"},     mem_req_wdata,      32'd0);
      chk({tag, "_wmask"},     32'(mem_req_wmask), 32'd0);
   endtask

   // Present an op in IDLE and step past the accepting edge.
   task automatic issue(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic rd, input logic wr);
      chk({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
      in_valid     = 1'b1;
      in_addr      = addr;
      in_wdata     = wdata;
      in_funct3    = f3;
      in_mem_read  = rd;
      in_mem_write = wr;
      tick;
      in_valid     = 1'b0;
      in_addr      = 32'h0;
      in_wdata     = 32'h0;
      in_funct3    = 3'b000;
      in_mem_read  = 1'b0;
      in_mem_write = 1'b0;
   endtask

   // Full memory op with zero-stall memory answering in the first WAIT cycle.
   task automatic run_mem(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input logic rd, input logic wr,
                          input logic [31:0] rdata, input logic [3:0] exp_mask,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_ld);
      issue(tag, addr, wdata, f3, rd, wr);
      chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd1);
      chk({tag, "_req_addr"},  mem_req_addr,       addr & 32'hFFFF_FFFC);
      chk({tag, "_req_wen"},   32'(mem_req_wen),   32'(wr & ~rd));
      chk({tag, "_req_wmask"}, 32'(mem_req_wmask), 32'(exp_mask));
      if (wr && !rd) chk({tag, "_req_wdata"}, mem_req_wdata, exp_wdata);
      chk({tag, "_ov_c1"},     32'(out_valid),     32'd0);
      tick;
      chk({tag, "_req_drop"},  32'(mem_req_valid), 32'd0);
      chk({tag, "_ov_c2"},     32'(out_valid),     32'd0);
      mem_resp_valid = 1'b1;
      mem_resp_rdata = rdata;
      tick;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = 32'h0;
      chk({tag, "_ov_c3"},     32'(out_valid),     32'd1);
      chk({tag, "_load"},      out_load_data,      exp_ld);
      chk({tag, "_fault"},     32'(out_fault),     32'd0);
      chk({tag, "_in_ready"},  32'(in_ready),      32'd0);
      tick;
      chk({tag, "_ov_idle"},   32'(out_valid),     32'd0);
      chk({tag, "_rdy_idle"},  32'(in_ready),      32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n          = 1'b0;
      in_valid       = 1'b0;
      in_addr        = 32'h0;
      in_wdata       = 32'h0;
      in_funct3      = 3'b000;
      in_mem_read    = 1'b0;
      in_mem_write   = 1'b0;
      out_ready      = 1'b1;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = 32'h0;
      tick;
      tick;
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      tick;

      run_mem("lw",  32'h8000_0004, 32'h0, 3'b010, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'b0000, 32'h0, 32'hDEAD_BEEF);
      run_mem("lb",  32'h8000_0003, 32'h0, 3'b000, 1'b1, 1'b0, 32'h80FF_1234, 4'b0000, 32'h0, 32'hFFFF_FF80);
      run_mem("lbu", 32'h8000_0003, 32'h0, 3'b100, 1'b1, 1'b0, 32'h80FF_1234, 4'b0000, 32'h0, 32'h0000_0080);
      run_mem("lhu", 32'h8000_0002, 32'h0, 3'b101, 1'b1, 1'b0, 32'h80FF_1234, 4'b0000, 32'h0, 32'h0000_80FF);
      run_mem("lh",  32'h8000_0002, 32'h0, 3'b001, 1'b1, 1'b0, 32'h80FF_1234, 4'b0000, 32'h0, 32'hFFFF_80FF);
      run_mem("lb0", 32'h0000_0010, 32'h0, 3'b000, 1'b1, 1'b0, 32'h1122_3374, 4'b0000, 32'h0, 32'h0000_0074);
      run_mem("sb",  32'h8000_0001, 32'h0000_00AB, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0010, 32'hABAB_ABAB, 32'h0);
      run_mem("sh",  32'h8000_0002, 32'h0000_1234, 3'b001, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b1100, 32'h1234_1234, 32'h0);
      run_mem("sw",  32'h0000_0020, 32'hCAFE_F00D, 3'b010, 1'b0, 1'b1, 32'h0,         4'b1111, 32'hCAFE_F00D, 32'h0);
      run_mem("f3_111", 32'h0000_0004, 32'h0, 3'b111, 1'b1, 1'b0, 32'h1357_9BDF, 4'b0000, 32'h0, 32'h1357_9BDF);
      run_mem("rdwr", 32'h0000_0008, 32'h5555_5555, 3'b010, 1'b1, 1'b1, 32'h1122_3344, 4'b0000, 32'h0, 32'h1122_3344);

      // Misaligned word: straight to DONE with fault, no memory request.
      issue("lw_mis", 32'h8000_0002, 32'h0, 3'b010, 1'b1, 1'b0);
      chk("lw_mis_req_valid", 32'(mem_req_valid), 32'd0);
      chk("lw_mis_out_valid", 32'(out_valid),     32'd1);
      chk("lw_mis_fault",     32'(out_fault),     32'd1);
      chk("lw_mis_load",      out_load_data,      32'd0);
      tick;
      chk("lw_mis_req_idle",  32'(mem_req_valid), 32'd0);
      chk("lw_mis_ov_idle",   32'(out_valid),     32'd0);

      issue("lh_mis", 32'h0000_0081, 32'h0, 3'b001, 1'b1, 1'b0);
      chk("lh_mis_req_valid", 32'(mem_req_valid), 32'd0);
      chk("lh_mis_fault",     32'(out_fault),     32'd1);
      tick;

      // Non-memory op passes through in one cycle with a clean result.
      issue("nop", 32'h0000_0003, 32'h0, 3'b010, 1'b0, 1'b0);
      chk("nop_out_valid", 32'(out_valid),     32'd1);
      chk("nop_fault",     32'(out_fault),     32'd0);
      chk("nop_load",      out_load_data,      32'd0);
      chk("nop_req_valid", 32'(mem_req_valid), 32'd0);
      tick;

      // Stalled request handshake followed by stalled result handshake.
      mem_req_ready = 1'b0;
      out_ready     = 1'b0;
      issue("stall", 32'h0000_0106, 32'h0000_5678, 3'b001, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("stall_req_valid", 32'(mem_req_valid), 32'd1);
         chk("stall_req_addr",  mem_req_addr,       32'h0000_0104);
         chk("stall_req_wmask", 32'(mem_req_wmask), 32'hC);
         chk("stall_req_wdata", mem_req_wdata,      32'h5678_5678);
         chk("stall_req_wen",   32'(mem_req_wen),   32'd1);
         tick;
      end
      chk("stall_req_hold", 32'(mem_req_valid), 32'd1);
      mem_req_ready = 1'b1;
      tick;
      chk("stall_wait_req", 32'(mem_req_valid), 32'd0);
      mem_resp_valid = 1'b1;
      tick;
      mem_resp_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_out_load",  out_load_data,  32'd0);
         chk("stall_out_fault", 32'(out_fault), 32'd0);
         chk("stall_in_ready",  32'(in_ready),  32'd0);
         tick;
      end
      out_ready = 1'b1;
      chk("stall_in_ready_hs", 32'(in_ready), 32'd0);
      tick;
      chk("stall_ov_after", 32'(out_valid), 32'd0);
      chk("stall_rdy_after", 32'(in_ready), 32'd1);

      // Reset while waiting on memory, then a stray response in IDLE.
      issue("rstw", 32'h0000_0020, 32'h0, 3'b010, 1'b1, 1'b0);
      tick;
      chk("rstw_in_wait", 32'(mem_req_valid), 32'd0);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk_reset_outputs("rstw");
      tick;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 32'hA5A5_A5A5;
      tick;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = 32'h0;
      chk_reset_outputs("stray");
      tick;
      chk_reset_outputs("stray2");

      // No response: times out after four WAIT cycles.
      issue("tmo", 32'h0000_0040, 32'h0, 3'b010, 1'b1, 1'b0);
      tick;
      for (int i = 0; i < 4; i++) begin
         chk("tmo_wait_ov", 32'(out_valid), 32'd0);
         tick;
      end
      chk("tmo_out_valid", 32'(out_valid), 32'd1);
      chk("tmo_fault",     32'(out_fault), 32'd1);
      chk("tmo_load",      out_load_data,  32'd0);
      tick;
      chk("tmo_idle_rdy",  32'(in_ready),  32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Load/store unit placed directly upstream of the writeback selector. Its registered load result drives the writeback selector's load_data input.
- Accepts one memory-class op at a time from the execute stage over a valid/ready handshake.
- Issues a single word-aligned request to data memory.
- Aligns and sign- or zero-extends returned load data, and generates byte masks for stores.
- Presents the result to writeback over a valid/ready handshake.

Parameters:
- XLEN, 32, data/address width.
- MEM_TIMEOUT, 255, maximum cycles waiting in WAIT; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  execute stage presents an op.
- in_ready  out  1  LSU can accept an op.
- in_addr  in  XLEN  effective address (ALU result).
- in_wdata  in  XLEN  store source (rs2).
- in_funct3  in  3  RV32 width/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- in_mem_read  in  1  load op.
- in_mem_write  in  1  store op.
- out_valid  out  1  result available to writeback.
- out_ready  in  1  writeback consumes the result.
- out_load_data  out  XLEN  extended load value; 0 for stores and non-memory ops.
- out_fault  out  1  misaligned access or timeout.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_wen  out  1  1 = write.
- mem_req_addr  out  XLEN  {in_addr[31:2], 2'b00}.
- mem_req_wdata  out  XLEN  store data shifted into its byte lanes.
- mem_req_wmask  out  4  byte enables; 0000 for reads.
- mem_resp_valid  in  1  response or write acknowledgement.
- mem_resp_rdata  in  XLEN  read word.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; in_ready=1.
  - out_valid=0, out_load_data=0, out_fault=0.
  - mem_req_valid=0, mem_req_wen=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wmask=0.
  - Timeout counter=0.
  - Reset mid-transaction abandons the op. Any later mem_resp_valid arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE. in_ready=1 only in IDLE.
- IDLE:
  - Accept on in_valid&in_ready; register addr, wdata, funct3 and op kind.
  - Neither read nor write -> DONE next cycle, load_data=0, fault=0.
  - Misaligned (h with addr[0]=1, w with addr[1:0]!=0) -> DONE, fault=1, no memory request.
  - Otherwise -> REQ.
- REQ:
  - mem_req_* driven from registers; valid held high and fields stable until mem_req_ready.
  - Handshake -> WAIT.
- WAIT:
  - On mem_resp_valid:
    - Load: select lane by addr[1:0], extend per funct3, write into out_load_data register.
    - Store: out_load_data=0.
    - Either case -> DONE.
  - A response arriving in the same cycle as the REQ handshake is not sampled. Memory must respond at least 1 cycle after accepting a request.
  - Counter increments each WAIT cycle. When it reaches MEM_TIMEOUT -> DONE, fault=1, load_data=0.
- DONE:
  - out_valid=1; out_* held stable until out_ready.
  - On out_ready -> IDLE; out_valid drops next cycle; counter cleared.
  - No new op is accepted in the same cycle as the DONE handshake.
- Minimum latency, accept to out_valid:
  - Non-memory/fault: 1 cycle.
  - Memory: 3 cycles (REQ 1, WAIT 1, DONE).
- Store lanes:
  - b: wdata[7:0] replicated to all 4 lanes, wmask=0001<<addr[1:0].
  - h: wdata[15:0] replicated to both halves, wmask=0011<<addr[1:0].
  - w: wmask=1111.
- funct3 011/110/111 are treated as w: unsigned-irrelevant, aligned check as w.
- in_mem_read and in_mem_write both set: treated as load.

Decomposition:
- Shared package holds:
  - funct3 width constants LS_B/H/W/BU/HU.
  - State enum encoding.
  - XLEN.
- One sub-module, lsu_align: purely combinational. Computes wmask and shifted wdata from (addr[1:0], funct3, wdata), and extended load data from (addr[1:0], funct3, rdata).

Test Plan:
- lw addr 0x80000004, mem returns 0xDEADBEEF one cycle after accept -> req addr 0x80000004, wmask 0000; out_load_data=0xDEADBEEF, fault=0, out_valid exactly 3 cycles after accept.
- lb addr 0x80000003, rdata 0x80FF1234 -> 0xFFFFFF80; lbu same -> 0x00000080; lhu addr 0x...2 -> 0x000080FF; lh -> 0xFFFF80FF.
- sb wdata 0x000000AB addr 0x...1 -> wmask 0010, wdata 0xABABABAB; sh addr 0x...2 wdata 0x1234 -> wmask 1100, wdata 0x12341234; out_load_data=0.
- lw addr 0x...2 -> no mem_req_valid ever; out_valid 1 cycle later, fault=1.
- mem_req_ready held low 5 cycles, then out_ready low 4 cycles in DONE -> req fields stable throughout REQ, out_* stable throughout DONE, in_ready=0 until the cycle after the out handshake.
- Reset asserted during WAIT, stray mem_resp_valid 2 cycles after reset -> all outputs at reset values, stays IDLE; with MEM_TIMEOUT=4 and no response -> fault=1 after 4 WAIT cycles.
